// File: rtl/vga_ram_arbiter_pkg.sv
// Shared types and constants for the VGA debug-display RAM write arbiter.
// Contents: source/state enums, default widths, round-robin successor helper.
package vga_pkg;

  localparam int unsigned VGA_ROW_ADDR_W = 6;
  localparam int unsigned VGA_DATA_W     = 32;
  localparam int unsigned VGA_NUM_SRC    = 3;
  localparam int unsigned VGA_CNT_W      = 8;

  typedef enum logic [1:0] {
    SRC_INSTR = 2'd0,
    SRC_REG   = 2'd1,
    SRC_DATA  = 2'd2
  } vga_src_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_state_e;

  // Next source in round-robin order, wrapping data -> instr.
  function automatic vga_src_e vga_src_next(input vga_src_e s);
    case (s)
      SRC_INSTR: return SRC_REG;
      SRC_REG:   return SRC_DATA;
      default:   return SRC_INSTR;
    endcase
  endfunction

endpackage

// File: rtl/vga_ram_arbiter_if.sv
// Bus bundle between the debug-tap requesters and the display-RAM write port.
// master: drives vblank and per-source req/req_addr/req_data, observes results.
// slave : the arbiter; drives ack, wr_en/src/addr/data, wr_count and busy.
interface vga_ram_arbiter_if import vga_pkg::*; #(
  parameter int unsigned ADDR_W = VGA_ROW_ADDR_W,
  parameter int unsigned DATA_W = VGA_DATA_W
) ();

  logic                                vblank;
  logic [VGA_NUM_SRC-1:0]              req;
  logic [VGA_NUM_SRC-1:0][ADDR_W-1:0]  req_addr;
  logic [VGA_NUM_SRC-1:0][DATA_W-1:0]  req_data;
  logic [VGA_NUM_SRC-1:0]              ack;
  logic                                wr_en;
  logic [1:0]                          wr_src;
  logic [ADDR_W-1:0]                   wr_addr;
  logic [DATA_W-1:0]                   wr_data;
  logic [VGA_CNT_W-1:0]                wr_count;
  logic                                busy;

  modport master (
    output vblank, req, req_addr, req_data,
    input  ack, wr_en, wr_src, wr_addr, wr_data, wr_count, busy
  );

  modport slave (
    input  vblank, req, req_addr, req_data,
    output ack, wr_en, wr_src, wr_addr, wr_data, wr_count, busy
  );

endinterface

// File: rtl/vga_ram_arbiter_rr_pick.sv
// Combinational 3-way round-robin selector.
// Ports: req_i (per-source request), rr_ptr_i (highest-priority source),
//        valid_c (any request), idx_c (winning source).
module vga_rr_pick import vga_pkg::*; (
  input  logic [VGA_NUM_SRC-1:0] req_i,
  input  vga_src_e               rr_ptr_i,
  output logic                   valid_c,
  output vga_src_e               idx_c
);

  vga_src_e p0;
  vga_src_e p1;
  vga_src_e p2;

  // Priority order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  always_comb begin
    p0      = rr_ptr_i;
    p1      = vga_src_next(p0);
    p2      = vga_src_next(p1);
    valid_c = |req_i;
    idx_c   = p0;
    if (req_i[p0])      idx_c = p0;
    else if (req_i[p1]) idx_c = p1;
    else if (req_i[p2]) idx_c = p2;
  end

endmodule

// File: rtl/vga_ram_arbiter.sv
// Round-robin write arbiter for the VGA debug-display RAM.
// Ports: clk (pixel clock), rst (async, active-low), bus (slave side of
//        vga_ram_arbiter_if: vblank, req*, ack, wr_*, wr_count, busy).
// Grants one write every two cycles at most, optionally only in vblank,
// capped at MAX_WR grants per frame window (cleared on vblank rising edge).
module vga_ram_arbiter import vga_pkg::*; #(
  parameter int unsigned ADDR_W      = VGA_ROW_ADDR_W,
  parameter int unsigned DATA_W      = VGA_DATA_W,
  parameter int unsigned MAX_WR      = 64,
  parameter bit          GATE_VBLANK = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  vga_ram_arbiter_if.slave   bus
);

  localparam int unsigned          CNT_W    = VGA_CNT_W;
  localparam logic [CNT_W-1:0]     MAX_WR_C = CNT_W'(MAX_WR);

  arb_state_e             state_q,   state_d;
  vga_src_e               rr_ptr_q,  rr_ptr_d;
  logic [VGA_NUM_SRC-1:0] ack_q,     ack_d;
  logic                   wr_en_q,   wr_en_d;
  vga_src_e               wr_src_q,  wr_src_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic [CNT_W-1:0]       wr_count_q, wr_count_d;
  logic                   busy_q,    busy_d;
  logic                   vblank_q;

  logic     pick_valid;
  vga_src_e pick_idx;
  logic     vblank_rise;
  logic     window_open;
  logic     grant;

  vga_rr_pick u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .valid_c  (pick_valid),
    .idx_c    (pick_idx)
  );

  assign vblank_rise = bus.vblank & ~vblank_q;
  assign window_open = !GATE_VBLANK || bus.vblank;
  assign grant       = window_open && (wr_count_q < MAX_WR_C) && pick_valid;

  // Next-state: outputs for the WRITE cycle are computed at the grant edge
  // so they appear registered one cycle after req is sampled.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    ack_d      = '0;
    wr_en_d    = 1'b0;
    busy_d     = 1'b0;
    wr_src_d   = wr_src_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    // A frame-window clear overrides the held count, including a write in flight.
    wr_count_d = vblank_rise ? '0 : wr_count_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          state_d    = ARB_WRITE;
          wr_en_d    = 1'b1;
          busy_d     = 1'b1;
          ack_d      = VGA_NUM_SRC'(1) << pick_idx;
          wr_src_d   = pick_idx;
          wr_addr_d  = bus.req_addr[pick_idx];
          wr_data_d  = bus.req_data[pick_idx];
          wr_count_d = wr_count_d + CNT_W'(1);
          rr_ptr_d   = vga_src_next(pick_idx);
        end
      end
      ARB_WRITE: state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= SRC_INSTR;
      ack_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_src_q   <= SRC_INSTR;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
      busy_q     <= 1'b0;
      vblank_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_q      <= ack_d;
      wr_en_q    <= wr_en_d;
      wr_src_q   <= wr_src_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
      busy_q     <= busy_d;
      vblank_q   <= bus.vblank;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_src   = wr_src_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_count = wr_count_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Directed self-checking bench for vga_ram_arbiter.
// dut_a: MAX_WR=64, vblank-gated. dut_b: MAX_WR=4, ungated. Both share inputs.
module tb_vga_ram_arbiter;

  logic             clk;
  logic             rst;
  logic             vblank;
  logic [2:0]       req;
  logic [2:0][5:0]  req_addr;
  logic [2:0][31:0] req_data;

  int total;
  int bad;

  vga_ram_arbiter_if #(.ADDR_W(6), .DATA_W(32)) ifa ();
  vga_ram_arbiter_if #(.ADDR_W(6), .DATA_W(32)) ifb ();

  assign ifa.vblank   = vblank;
  assign ifa.req      = req;
  assign ifa.req_addr = req_addr;
  assign ifa.req_data = req_data;
  assign ifb.vblank   = vblank;
  assign ifb.req      = req;
  assign ifb.req_addr = req_addr;
  assign ifb.req_data = req_data;

  vga_ram_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_WR(64), .GATE_VBLANK(1'b1)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );

  vga_ram_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_WR(4), .GATE_VBLANK(1'b0)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; vblank = 1'b0; req_addr = '0; req_data = '0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; vblank = 1'b0; req_addr = '0; req_data = '0;
    #3;
    total++; if (ifa.ack !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b want=000", ifa.ack); end
    total++; if (ifa.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", ifa.wr_en); end
    total++; if (ifa.wr_src !== 2'd0) begin bad++; $display("FAIL reset_wr_src got=%0d want=0", ifa.wr_src); end
    total++; if (ifa.wr_addr !== 6'd0) begin bad++; $display("FAIL reset_wr_addr got=%0d want=0", ifa.wr_addr); end
    total++; if (ifa.wr_data !== 32'd0) begin bad++; $display("FAIL reset_wr_data got=%h want=0", ifa.wr_data); end
    total++; if (ifa.wr_count !== 8'd0) begin bad++; $display("FAIL reset_wr_count got=%0d want=0", ifa.wr_count); end
    total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", ifa.busy); end
    step(); step();
    rst = 1'b1;
    step();
    total++; if (ifa.wr_en !== 1'b0) begin bad++; $display("FAIL reset_idle_wr_en got=%b want=0", ifa.wr_en); end
  endtask

  task automatic test_single();
    do_reset();
    vblank = 1'b1; req = 3'b010; req_addr[1] = 6'd5; req_data[1] = 32'hDEADBEEF;
    step();
    total++; if (ifa.wr_en !== 1'b1) begin bad++; $display("FAIL single_wr_en got=%b want=1", ifa.wr_en); end
    total++; if (ifa.wr_src !== 2'd1) begin bad++; $display("FAIL single_wr_src got=%0d want=1", ifa.wr_src); end
    total++; if (ifa.wr_addr !== 6'd5) begin bad++; $display("FAIL single_wr_addr got=%0d want=5", ifa.wr_addr); end
    total++; if (ifa.wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wr_data got=%h want=deadbeef", ifa.wr_data); end
    total++; if (ifa.ack !== 3'b010) begin bad++; $display("FAIL single_ack got=%b want=010", ifa.ack); end
    total++; if (ifa.wr_count !== 8'd1) begin bad++; $display("FAIL single_wr_count got=%0d want=1", ifa.wr_count); end
    total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", ifa.busy); end
    req = 3'b000;
    step();
    total++; if (ifa.wr_en !== 1'b0) begin bad++; $display("FAIL single_after_wr_en got=%b want=0", ifa.wr_en); end
    total++; if (ifa.ack !== 3'b000) begin bad++; $display("FAIL single_after_ack got=%b want=000", ifa.ack); end
    total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL single_after_busy got=%b want=0", ifa.busy); end
    total++; if (ifa.wr_count !== 8'd1) begin bad++; $display("FAIL single_after_count got=%0d want=1", ifa.wr_count); end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_ack;
    do_reset();
    vblank = 1'b1; req = 3'b111;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_ack = (i % 2 == 0) ? 3'(1 << ((i / 2) % 3)) : 3'b000;
      total++;
      if (ifa.ack !== exp_ack) begin
        bad++; $display("FAIL fair_ack cycle=%0d got=%b want=%b", i, ifa.ack, exp_ack);
      end
    end
    total++; if (ifa.wr_count !== 8'd6) begin bad++; $display("FAIL fair_count got=%0d want=6", ifa.wr_count); end
    req = 3'b000;
  endtask

  task automatic test_gating();
    do_reset();
    vblank = 1'b0; req = 3'b100; req_addr[2] = 6'd7; req_data[2] = 32'h12345678;
    step();
    total++; if (ifb.wr_en !== 1'b1) begin bad++; $display("FAIL ungated_wr_en got=%b want=1", ifb.wr_en); end
    total++; if (ifa.wr_en !== 1'b0) begin bad++; $display("FAIL gate_closed_wr_en cycle=0 got=%b want=0", ifa.wr_en); end
    for (int i = 1; i < 4; i++) begin
      step();
      total++; if (ifa.wr_en !== 1'b0) begin bad++; $display("FAIL gate_closed_wr_en cycle=%0d got=%b want=0", i, ifa.wr_en); end
    end
    vblank = 1'b1;
    step();
    total++; if (ifa.wr_en !== 1'b1) begin bad++; $display("FAIL gate_open_wr_en got=%b want=1", ifa.wr_en); end
    total++; if (ifa.ack !== 3'b100) begin bad++; $display("FAIL gate_open_ack got=%b want=100", ifa.ack); end
    total++; if (ifa.wr_addr !== 6'd7) begin bad++; $display("FAIL gate_open_addr got=%0d want=7", ifa.wr_addr); end
    total++; if (ifa.wr_data !== 32'h12345678) begin bad++; $display("FAIL gate_open_data got=%h want=12345678", ifa.wr_data); end
    req = 3'b000;
    step();
  endtask

  task automatic test_vblank_fall();
    do_reset();
    vblank = 1'b1; req = 3'b010; req_addr[1] = 6'd9; req_data[1] = 32'hA5A5A5A5;
    step();
    total++; if (ifa.wr_en !== 1'b1) begin bad++; $display("FAIL fall_write got=%b want=1", ifa.wr_en); end
    vblank = 1'b0;
    step();
    total++; if (ifa.wr_en !== 1'b0) begin bad++; $display("FAIL fall_complete got=%b want=0", ifa.wr_en); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (ifa.wr_en !== 1'b0) begin bad++; $display("FAIL fall_no_grant cycle=%0d got=%b want=0", i, ifa.wr_en); end
    end
    req = 3'b000;
  endtask

  task automatic test_quota();
    int  acks;
    bit  resumed;
    do_reset();
    vblank = 1'b0; req = 3'b001; acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ifb.ack[0] === 1'b1) acks++;
    end
    total++; if (acks !== 4) begin bad++; $display("FAIL quota_acks got=%0d want=4", acks); end
    total++; if (ifb.wr_count !== 8'd4) begin bad++; $display("FAIL quota_count got=%0d want=4", ifb.wr_count); end
    vblank = 1'b1;
    step();
    total++; if (ifb.wr_count !== 8'd0) begin bad++; $display("FAIL quota_clear got=%0d want=0", ifb.wr_count); end
    resumed = 1'b0;
    for (int i = 0; i < 4 && !resumed; i++) begin
      step();
      if (ifb.ack[0] === 1'b1) resumed = 1'b1;
    end
    total++; if (resumed !== 1'b1) begin bad++; $display("FAIL quota_resume got=%b want=1", resumed); end
    total++; if (ifb.wr_count !== 8'd1) begin bad++; $display("FAIL quota_resume_count got=%0d want=1", ifb.wr_count); end
    req = 3'b000;
  endtask

  task automatic test_edge_collision();
    do_reset();
    vblank = 1'b0; req = 3'b001; req_addr[0] = 6'd3;
    step();
    total++; if (ifb.wr_en !== 1'b1) begin bad++; $display("FAIL coll_write got=%b want=1", ifb.wr_en); end
    total++; if (ifb.wr_count !== 8'd1) begin bad++; $display("FAIL coll_count_pre got=%0d want=1", ifb.wr_count); end
    vblank = 1'b1; req = 3'b000;
    step();
    total++; if (ifb.wr_count !== 8'd0) begin bad++; $display("FAIL coll_count_post got=%0d want=0", ifb.wr_count); end
    total++; if (ifb.wr_en !== 1'b0) begin bad++; $display("FAIL coll_wr_en_post got=%b want=0", ifb.wr_en); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    vblank = 1'b1; req = 3'b111;
    step();
    total++; if (ifa.ack !== 3'b001) begin bad++; $display("FAIL rstw_first got=%b want=001", ifa.ack); end
    step(); step();
    total++; if (ifa.ack !== 3'b010) begin bad++; $display("FAIL rstw_second got=%b want=010", ifa.ack); end
    rst = 1'b0;
    #1;
    total++; if (ifa.ack !== 3'b000) begin bad++; $display("FAIL rstw_ack got=%b want=000", ifa.ack); end
    total++; if (ifa.wr_en !== 1'b0) begin bad++; $display("FAIL rstw_wr_en got=%b want=0", ifa.wr_en); end
    total++; if (ifa.wr_count !== 8'd0) begin bad++; $display("FAIL rstw_count got=%0d want=0", ifa.wr_count); end
    total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL rstw_busy got=%b want=0", ifa.busy); end
    step();
    rst = 1'b1;
    step();
    total++; if (ifa.ack !== 3'b001) begin bad++; $display("FAIL rstw_ptr_reset got=%b want=001", ifa.ack); end
    total++; if (ifa.wr_count !== 8'd1) begin bad++; $display("FAIL rstw_count_after got=%0d want=1", ifa.wr_count); end
    req = 3'b000;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_fairness();
    test_gating();
    test_vblank_fall();
    test_quota();
    test_edge_collision();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog elapsed got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
